// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream-format constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_BITS / 8;

  function automatic int unsigned bytes_per_word(input int unsigned n);
    return n / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - places stream bytes into little-endian lanes of a word register
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [7:0]   byte_i,
  output logic [N-1:0] word_next_o,
  output logic         word_complete_o
);

  localparam int unsigned BPW = bytes_per_word(N);
  localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST = IW'(BPW - 1);

  logic [N-1:0]  word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      for (int l = 0; l < BPW; l++) begin
        if (IW'(l) == idx_q) word_d[8*l +: 8] = byte_i;
      end
      idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // Next-word view lets the write port capture the final byte on the same edge.
  assign word_next_o     = word_d;
  assign word_complete_o = load_i && !clr_i && (idx_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a headered byte stream into instruction memory and holds the core until done
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          core_hold,
  output logic          done,
  output logic          error
);

  state_t        state_q;
  logic [15:0]   count_q;
  logic [AW:0]   word_idx_q;
  logic          byte_ready_q, imem_we_q, core_hold_q, done_q, error_q;
  logic [AW-1:0] imem_addr_q;
  logic [N-1:0]  imem_wdata_q;

  logic          xfer;
  logic [15:0]   hdr_count;
  logic [15:0]   next_idx;
  logic [N-1:0]  word_next;
  logic          word_complete;

  assign xfer      = byte_valid && byte_ready_q;
  assign hdr_count = {byte_in, count_q[7:0]};
  assign next_idx  = 16'(word_idx_q) + 16'd1;

  byte_packer #(.N(N)) u_packer (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (xfer && (state_q == HDR1)),
    .load_i          (xfer && (state_q == DATA)),
    .byte_i          (byte_in),
    .word_next_o     (word_next),
    .word_complete_o (word_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q      <= HDR0;
          byte_ready_q <= 1'b1;
        end
        HDR0: if (xfer) begin
          count_q[7:0] <= byte_in;
          state_q      <= HDR1;
        end
        HDR1: if (xfer) begin
          count_q[15:8] <= byte_in;
          if (hdr_count == 16'd0) begin
            state_q      <= DONE;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
            core_hold_q  <= 1'b0;
          end else if (hdr_count > 16'(DEPTH)) begin
            state_q      <= ERR;
            byte_ready_q <= 1'b0;
            error_q      <= 1'b1;
          end else begin
            state_q    <= DATA;
            word_idx_q <= '0;
          end
        end
        DATA: if (word_complete) begin
          state_q      <= WRITE;
          byte_ready_q <= 1'b0;
          imem_we_q    <= 1'b1;
          imem_addr_q  <= word_idx_q[AW-1:0];
          imem_wdata_q <= word_next;
        end
        WRITE: begin
          word_idx_q <= next_idx[AW:0];
          if (next_idx == count_q) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
          end else begin
            state_q      <= DATA;
            byte_ready_q <= 1'b1;
          end
        end
        DONE, ERR: if (start) begin
          state_q      <= HDR0;
          byte_ready_q <= 1'b1;
          core_hold_q  <= 1'b1;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
